// File: rtl/bp_sched_pkg.sv
// ============================================================
// bp_sched_pkg : shared types and constants for the predictor
//                access scheduler. Rev 1.0
// ============================================================
`default_nettype none

package bp_sched_pkg;

  typedef enum logic [1:0] {
    GNT_IDLE   = 2'd0,
    GNT_FETCH  = 2'd1,
    GNT_UPDATE = 2'd2
  } grant_e;

  localparam int unsigned DEF_FIFO_DEPTH   = 4;
  localparam int unsigned DEF_MAX_INFLIGHT = 8;
  localparam int unsigned DEF_STARVE_LIMIT = 3;

  // Bits needed to hold any value in 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_result_fifo.sv
// ============================================================
// bp_result_fifo : 1-bit resolution FIFO, power-of-2 depth,
//                  no write-to-read bypass. Rev 1.0
// ============================================================
`default_nettype none

module bp_result_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          push_data,
  input  logic                          pop,
  output logic                          head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    full     = (count_q == (PW+1)'(FIFO_DEPTH));
    empty    = (count_q == '0);
    head     = mem_q[rd_ptr_q];
    count    = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Simultaneous push and pop cancel out in the occupancy count.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_access_scheduler.sv
// ============================================================
// bp_access_scheduler : arbitrates fetch lookups and commit
//                       updates onto a single-port predictor. Rev 1.0
// ============================================================
`default_nettype none

module bp_access_scheduler
  import bp_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int unsigned IW          = cnt_width(MAX_INFLIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  output logic          fetch_ready,
  output logic          fetch_pred_valid,
  output logic          fetch_pred,
  input  logic          resolve_valid,
  input  logic          resolve_taken,
  output logic          resolve_ready,
  input  logic          flush,
  output logic          bp_request,
  output logic          bp_result,
  output logic          bp_taken,
  input  logic          bp_prediction,
  output logic [IW-1:0] inflight,
  output logic          underflow_err
);

  localparam int unsigned SW = cnt_width(STARVE_LIMIT);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [IW-1:0] inflight_q, inflight_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          underflow_q, underflow_d;
  logic          bp_request_q, bp_request_d;
  logic          bp_result_q, bp_result_d;
  logic          bp_taken_q, bp_taken_d;
  logic          pred_valid_q, pred_valid_d;
  logic          pred_q, pred_d;

  logic          fifo_head, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          upd_force, fetch_acc, resolve_acc, pop;
  grant_e        grant;

  bp_result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resolve_acc),
    .push_data (resolve_taken),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    upd_force     = (fifo_count != '0) && (fifo_full || (starve_q >= SW'(STARVE_LIMIT)));
    fetch_ready   = (inflight_q < IW'(MAX_INFLIGHT)) && !flush && !upd_force;
    resolve_ready = !fifo_full;
    fetch_acc     = fetch_req && fetch_ready;
    resolve_acc   = resolve_valid && resolve_ready;

    if (fetch_acc)              grant = GNT_FETCH;
    else if (fifo_count != '0)  grant = GNT_UPDATE;
    else                        grant = GNT_IDLE;
    pop = (grant == GNT_UPDATE);

    bp_request_d = (grant == GNT_FETCH);
    bp_result_d  = (grant == GNT_UPDATE);
    bp_taken_d   = pop ? fifo_head : bp_taken_q;
    pred_valid_d = bp_request_q;
    pred_d       = bp_request_q ? bp_prediction : pred_q;

    // Starvation is counted only while a queued update loses to a fetch.
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (grant == GNT_FETCH && starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end

    underflow_d = underflow_q || (resolve_acc && inflight_q == '0);
    inflight_d  = inflight_q;
    if (flush) begin
      inflight_d = '0;
    end else if (fetch_acc && !resolve_acc) begin
      inflight_d = inflight_q + IW'(1);
    end else if (resolve_acc && !fetch_acc && inflight_q != '0) begin
      inflight_d = inflight_q - IW'(1);
    end

    bp_request       = bp_request_q;
    bp_result        = bp_result_q;
    bp_taken         = bp_taken_q;
    fetch_pred_valid = pred_valid_q;
    fetch_pred       = pred_q;
    inflight         = inflight_q;
    underflow_err    = underflow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q   <= '0;
      starve_q     <= '0;
      underflow_q  <= 1'b0;
      bp_request_q <= 1'b0;
      bp_result_q  <= 1'b0;
      bp_taken_q   <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_q       <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      starve_q     <= starve_d;
      underflow_q  <= underflow_d;
      bp_request_q <= bp_request_d;
      bp_result_q  <= bp_result_d;
      bp_taken_q   <= bp_taken_d;
      pred_valid_q <= pred_valid_d;
      pred_q       <= pred_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/bp_access_scheduler.md
Name: bp_access_scheduler

Overview:
- Sequences all accesses to the single-port branch predictor (one request/result strobe per cycle; a request takes precedence over a result inside the predictor).
- Arbitrates between fetch-side prediction lookups and commit-side resolution updates.
- Buffers resolutions in a FIFO, bounds the number of unresolved predictions in flight, and prevents update starvation.

Parameters:
- FIFO_DEPTH, 4, resolution FIFO entries; power of 2, ≥2.
- MAX_INFLIGHT, 8, maximum predictions issued but not yet resolved.
- STARVE_LIMIT, 3, cycles a non-empty FIFO may be bypassed before an update is forced.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch requests a prediction.
- fetch_ready  out  1  combinational; lookup accepted when fetch_req && fetch_ready.
- fetch_pred_valid  out  1  registered; prediction available this cycle.
- fetch_pred  out  1  predicted direction; valid only with fetch_pred_valid.
- resolve_valid  in  1  commit presents a resolved branch.
- resolve_taken  in  1  actual outcome.
- resolve_ready  out  1  combinational; equals !fifo_full.
- flush  in  1  pipeline flush; discards in-flight predictions.
- bp_request  out  1  registered; drives predictor request.
- bp_result  out  1  registered; drives predictor result.
- bp_taken  out  1  registered; drives predictor taken.
- bp_prediction  in  1  predictor prediction output.
- inflight  out  $clog2(MAX_INFLIGHT+1)  unresolved prediction count.
- underflow_err  out  1  sticky; resolve accepted while inflight==0.

Behaviour:
- Reset (asynchronous, any time): FIFO emptied (pointers 0), starve counter 0, inflight 0, underflow_err 0, bp_request/bp_result/bp_taken 0, fetch_pred_valid 0. A pending prediction return is dropped.
- Per-cycle arbitration (cycle t):
  - fetch_elig = fetch_req && inflight<MAX_INFLIGHT && !flush.
  - upd_force = fifo_count!=0 && (fifo_full || starve_cnt>=STARVE_LIMIT).
  - fetch_ready = inflight<MAX_INFLIGHT && !flush && !upd_force.
  - Grant FETCH if fetch_elig && !upd_force.
  - Otherwise grant UPDATE if fifo_count!=0.
  - Otherwise IDLE.
  - At most one grant per cycle; bp_request and bp_result are never high together.
- FETCH grant at t:
  - bp_request=1 during t+1.
  - fetch_pred_valid=1 during t+2; fetch_pred=bp_prediction.
  - Fixed lookup latency is 2 cycles.
  - Back-to-back grants give one prediction per cycle.
- UPDATE grant at t:
  - FIFO pops its head.
  - bp_result=1 and bp_taken=head during t+1.
  - Updates issue strictly in resolve order.
- FIFO: push on resolve_valid && resolve_ready.
  - A push into an empty FIFO is eligible for pop no earlier than the next cycle (no bypass).
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- starve_cnt: cleared on pop or when FIFO empty; otherwise +1 per cycle in which the FIFO is non-empty and FETCH wins. Saturates at STARVE_LIMIT.
- inflight:
  - +1 on fetch accept, −1 on resolve accept, unchanged if both occur.
  - At MAX_INFLIGHT, fetch_ready=0.
  - Resolve accepted at inflight==0: count stays 0 and underflow_err is set (sticky until reset). The entry is still pushed.
- flush:
  - inflight←0 regardless of same-cycle resolve.
  - fetch_ready=0 in that cycle.
  - FIFO contents and an already-issued bp_request/fetch_pred_valid pipeline are unaffected; resolutions remain real training data.
- IDLE: bp_request=bp_result=0. bp_taken holds its last value (don't-care).

Decomposition:
- Package bp_sched_pkg holds:
  - grant encoding typedef (GNT_IDLE, GNT_FETCH, GNT_UPDATE);
  - default parameter constants;
  - a clog2-based width helper.
- Natural sub-module: bp_result_fifo (1-bit data, FIFO_DEPTH, push/pop, full/empty/count).
- Arbitration, counters and output registers stay in bp_access_scheduler.

Test Plan:
- Single lookup: fetch_req=1 for one cycle at t=0, FIFO empty → bp_request high at t=1; fetch_pred_valid=1 at t=2 with fetch_pred equal to bp_prediction; inflight=1.
- Starvation: fetch_req held high, one resolve (taken=1) pushed at t=0, STARVE_LIMIT=3 → FETCH wins for 3 cycles, then fetch_ready=0 for one cycle; bp_result=1 and bp_taken=1 follow one cycle later.
- FIFO full: 4 resolves pushed with fetch continuously requesting → resolve_ready=0 at count 4; updates forced; ordering T,N,T,T is preserved on bp_taken.
- Inflight limit: 8 accepted lookups with no resolves → fetch_ready=0 with inflight=8. One resolve → inflight=7 and fetch resumes.
- Flush and underflow: inflight=5, flush asserted with a simultaneous resolve → inflight=0. A further resolve → underflow_err=1 and stays set. A queued FIFO entry still drains.
- Reset mid-operation: rst_n low while bp_request=1 and FIFO holds 2 entries → all outputs 0 immediately. After release the FIFO is empty and there are no stray bp_result pulses.
